// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C role arbiter: role encoding, arbiter states
// and the bus-free counter width helper.
package i2c_pkg;

    localparam logic ROLE_SLAVE  = 1'b0;
    localparam logic ROLE_MASTER = 1'b1;

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        BUS_WAIT
    } arb_state_t;

    function automatic int free_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/bus_free_counter.sv
// Counts consecutive cycles with both bus lines high while enabled; clears on
// any low sample, on disable and on reaching the terminal count.
module bus_free_counter
    import i2c_pkg::*;
#(
    parameter int unsigned BUS_FREE_CYCLES = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic bus_high,
    output logic terminal
);

    localparam int CW = free_cnt_width(int'(BUS_FREE_CYCLES));
    localparam logic [CW-1:0] TC = CW'(BUS_FREE_CYCLES - 1);

    logic [CW-1:0] count;

    assign terminal = (count == TC);

    // Terminal count is the exit point, so the counter never wraps.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (!enable || !bus_high || terminal) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_role_arbiter.sv
// Grants the I2C pads and FIFO ports to either the master or slave engine;
// role changes wait for the granted engine to drain and the bus to go idle.
//
// state    | meaning
// ACTIVE   | granted engine owns pads/FIFO, no change requested
// DRAIN    | change requested, granted engine finishing its transaction
// BUS_WAIT | both engines off, waiting for BUS_FREE_CYCLES idle samples
module i2c_role_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned BUS_FREE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       ms_select,
    input  logic       SDA_sync,
    input  logic       SCL_sync,
    input  logic       busy_master,
    input  logic       busy_slave,
    input  logic       SDA_out_master,
    input  logic       SCL_out_master,
    input  logic       SDA_out_slave,
    input  logic       SCL_out_slave,
    input  logic       TX_read_enable_master,
    input  logic       TX_read_enable_slave,
    input  logic       RX_write_enable_master,
    input  logic       RX_write_enable_slave,
    input  logic [7:0] rx_data_master,
    input  logic [7:0] rx_data_slave,
    input  logic       set_transaction_complete_master,
    input  logic       set_transaction_complete_slave,
    input  logic       ack_error_set_master,
    input  logic       ack_error_set_slave,
    output logic       master_enable,
    output logic       slave_enable,
    output logic       SDA_out,
    output logic       SCL_out,
    output logic       TX_read_enable,
    output logic       RX_write_enable,
    output logic [7:0] rx_data,
    output logic       set_transaction_complete,
    output logic       ack_error_set,
    output logic       busy,
    output logic       role,
    output logic       switch_pending
);

    arb_state_t state;
    logic       role_q;
    logic       bus_high;
    logic       in_wait;
    logic       granted_busy;
    logic       free_tc;

    assign bus_high     = SDA_sync & SCL_sync;
    assign in_wait      = (state == BUS_WAIT);
    assign granted_busy = (role_q == ROLE_MASTER) ? busy_master : busy_slave;
    assign role         = role_q;

    bus_free_counter #(
        .BUS_FREE_CYCLES(BUS_FREE_CYCLES)
    ) u_free_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .enable   (in_wait),
        .bus_high (bus_high),
        .terminal (free_tc)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= ACTIVE;
            role_q <= ROLE_SLAVE;
        end else begin
            case (state)
                ACTIVE: begin
                    if (ms_select != role_q) state <= DRAIN;
                end
                DRAIN: begin
                    if (ms_select == role_q) state <= ACTIVE;
                    else if (!granted_busy)  state <= BUS_WAIT;
                end
                BUS_WAIT: begin
                    // Request is re-sampled here; it may match the old role.
                    if (bus_high && free_tc) begin
                        role_q <= ms_select;
                        state  <= ACTIVE;
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

    always_comb begin
        master_enable            = 1'b0;
        slave_enable             = 1'b0;
        SDA_out                  = 1'b1;
        SCL_out                  = 1'b1;
        TX_read_enable           = 1'b0;
        RX_write_enable          = 1'b0;
        set_transaction_complete = 1'b0;
        ack_error_set            = 1'b0;
        busy                     = 1'b1;
        rx_data                  = (role_q == ROLE_MASTER) ? rx_data_master : rx_data_slave;
        switch_pending           = (state != ACTIVE);
        if (!in_wait) begin
            busy = granted_busy;
            if (role_q == ROLE_MASTER) begin
                master_enable            = 1'b1;
                SDA_out                  = SDA_out_master;
                SCL_out                  = SCL_out_master;
                TX_read_enable           = TX_read_enable_master;
                RX_write_enable          = RX_write_enable_master;
                set_transaction_complete = set_transaction_complete_master;
                ack_error_set            = ack_error_set_master;
            end else begin
                slave_enable             = 1'b1;
                SDA_out                  = SDA_out_slave;
                SCL_out                  = SCL_out_slave;
                TX_read_enable           = TX_read_enable_slave;
                RX_write_enable          = RX_write_enable_slave;
                set_transaction_complete = set_transaction_complete_slave;
                ack_error_set            = ack_error_set_slave;
            end
        end
    end

endmodule

// File: tb/tb_i2c_role_arbiter.sv
// Bench for i2c_role_arbiter: directed scenarios plus a randomized run, all
// checked every cycle against a behavioural model of the role-handover rules.
module tb_i2c_role_arbiter;

    localparam int BFC = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       ms_select = 1'b0;
    logic       SDA_sync = 1'b1, SCL_sync = 1'b1;
    logic       busy_master = 1'b0, busy_slave = 1'b0;
    logic       SDA_out_master = 1'b1, SCL_out_master = 1'b1;
    logic       SDA_out_slave = 1'b1, SCL_out_slave = 1'b1;
    logic       TX_read_enable_master = 1'b0, TX_read_enable_slave = 1'b0;
    logic       RX_write_enable_master = 1'b0, RX_write_enable_slave = 1'b0;
    logic [7:0] rx_data_master = 8'h00, rx_data_slave = 8'h00;
    logic       set_transaction_complete_master = 1'b0, set_transaction_complete_slave = 1'b0;
    logic       ack_error_set_master = 1'b0, ack_error_set_slave = 1'b0;

    logic       master_enable, slave_enable, SDA_out, SCL_out;
    logic       TX_read_enable, RX_write_enable;
    logic [7:0] rx_data;
    logic       set_transaction_complete, ack_error_set, busy, role, switch_pending;

    i2c_role_arbiter #(.BUS_FREE_CYCLES(BFC)) dut (
        .clk(clk), .n_rst(n_rst), .ms_select(ms_select),
        .SDA_sync(SDA_sync), .SCL_sync(SCL_sync),
        .busy_master(busy_master), .busy_slave(busy_slave),
        .SDA_out_master(SDA_out_master), .SCL_out_master(SCL_out_master),
        .SDA_out_slave(SDA_out_slave), .SCL_out_slave(SCL_out_slave),
        .TX_read_enable_master(TX_read_enable_master), .TX_read_enable_slave(TX_read_enable_slave),
        .RX_write_enable_master(RX_write_enable_master), .RX_write_enable_slave(RX_write_enable_slave),
        .rx_data_master(rx_data_master), .rx_data_slave(rx_data_slave),
        .set_transaction_complete_master(set_transaction_complete_master),
        .set_transaction_complete_slave(set_transaction_complete_slave),
        .ack_error_set_master(ack_error_set_master), .ack_error_set_slave(ack_error_set_slave),
        .master_enable(master_enable), .slave_enable(slave_enable),
        .SDA_out(SDA_out), .SCL_out(SCL_out),
        .TX_read_enable(TX_read_enable), .RX_write_enable(RX_write_enable),
        .rx_data(rx_data),
        .set_transaction_complete(set_transaction_complete), .ack_error_set(ack_error_set),
        .busy(busy), .role(role), .switch_pending(switch_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, whether a handover is draining or waiting for
    // idle, and how many consecutive idle samples have been seen so far.
    logic m_role  = 1'b0;
    logic m_drain = 1'b0;
    logic m_wait  = 1'b0;
    int   m_run   = 0;

    always @(posedge clk or negedge n_rst) begin
        logic g_busy;
        if (!n_rst) begin
            m_role  <= 1'b0;
            m_drain <= 1'b0;
            m_wait  <= 1'b0;
            m_run   <= 0;
        end else begin
            g_busy = m_role ? busy_master : busy_slave;
            if (m_wait) begin
                if (SDA_sync && SCL_sync) begin
                    if (m_run + 1 >= BFC) begin
                        m_role <= ms_select;
                        m_wait <= 1'b0;
                        m_run  <= 0;
                    end else begin
                        m_run <= m_run + 1;
                    end
                end else begin
                    m_run <= 0;
                end
            end else if (m_drain) begin
                if (ms_select == m_role) begin
                    m_drain <= 1'b0;
                end else if (!g_busy) begin
                    m_drain <= 1'b0;
                    m_wait  <= 1'b1;
                end
            end else if (ms_select != m_role) begin
                m_drain <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic own;
        own = !m_wait;
        check1("master_enable", master_enable, own & m_role);
        check1("slave_enable", slave_enable, own & ~m_role);
        check1("both_enables", master_enable & slave_enable, 1'b0);
        check1("SDA_out", SDA_out, own ? (m_role ? SDA_out_master : SDA_out_slave) : 1'b1);
        check1("SCL_out", SCL_out, own ? (m_role ? SCL_out_master : SCL_out_slave) : 1'b1);
        check1("TX_read_enable", TX_read_enable,
               own & (m_role ? TX_read_enable_master : TX_read_enable_slave));
        check1("RX_write_enable", RX_write_enable,
               own & (m_role ? RX_write_enable_master : RX_write_enable_slave));
        check1("set_transaction_complete", set_transaction_complete,
               own & (m_role ? set_transaction_complete_master : set_transaction_complete_slave));
        check1("ack_error_set", ack_error_set,
               own & (m_role ? ack_error_set_master : ack_error_set_slave));
        check1("busy", busy, own ? (m_role ? busy_master : busy_slave) : 1'b1);
        check1("role", role, m_role);
        check1("switch_pending", switch_pending, m_drain | m_wait);
        check8("rx_data", rx_data, m_role ? rx_data_master : rx_data_slave);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        TX_read_enable_master = 1'b0; TX_read_enable_slave = 1'b0;
        RX_write_enable_master = 1'b0; RX_write_enable_slave = 1'b0;
        set_transaction_complete_master = 1'b0; set_transaction_complete_slave = 1'b0;
        ack_error_set_master = 1'b0; ack_error_set_slave = 1'b0;
        SDA_out_master = 1'b1; SCL_out_master = 1'b1;
        SDA_out_slave = 1'b1; SCL_out_slave = 1'b1;
    endtask

    initial begin
        #1;
        check1("rst_role", role, 1'b0);
        check1("rst_slave_enable", slave_enable, 1'b1);
        check1("rst_master_enable", master_enable, 1'b0);
        check1("rst_SDA_out", SDA_out, 1'b1);
        check1("rst_SCL_out", SCL_out, 1'b1);
        check1("rst_switch_pending", switch_pending, 1'b0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        // Slave owns the bus; master strobes must be ignored.
        RX_write_enable_slave = 1'b1; rx_data_slave = 8'hA5;
        RX_write_enable_master = 1'b1; rx_data_master = 8'h3C;
        TX_read_enable_master = 1'b1; set_transaction_complete_master = 1'b1;
        SDA_out_slave = 1'b0; SDA_out_master = 1'b1;
        @(negedge clk);
        check1("slave_rx_we", RX_write_enable, 1'b1);
        check8("slave_rx_data", rx_data, 8'hA5);
        check1("master_tx_ignored", TX_read_enable, 1'b0);
        check1("master_stc_ignored", set_transaction_complete, 1'b0);
        check1("slave_sda", SDA_out, 1'b0);
        step();
        clear_strobes();

        // Switch to master while the slave is busy for 20 cycles.
        busy_slave = 1'b1; ms_select = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check1("drain_slave_enable", slave_enable, 1'b1);
            check1("drain_pending", switch_pending, 1'b1);
            step();
        end
        busy_slave = 1'b0;
        step();
        SDA_out_slave = 1'b0; TX_read_enable_slave = 1'b1;
        for (int i = 0; i < BFC; i++) begin
            @(negedge clk);
            check1("wait_master_enable", master_enable, 1'b0);
            check1("wait_slave_enable", slave_enable, 1'b0);
            check1("wait_sda_released", SDA_out, 1'b1);
            check1("wait_tx_gated", TX_read_enable, 1'b0);
            check1("wait_busy", busy, 1'b1);
            check1("model_waiting", m_wait, 1'b1);
            step();
        end
        clear_strobes();
        @(negedge clk);
        check1("switched_role", role, 1'b1);
        check1("switched_master_enable", master_enable, 1'b1);
        check1("switched_slave_enable", slave_enable, 1'b0);
        check1("switched_pending", switch_pending, 1'b0);
        check1("model_role_master", m_role, 1'b1);

        // Back to slave with master idle: one DRAIN cycle, glitch at cycle 5.
        busy_master = 1'b0; ms_select = 1'b0;
        step();
        @(negedge clk);
        check1("drain1_pending", switch_pending, 1'b1);
        check1("drain1_master_enable", master_enable, 1'b1);
        step();
        @(negedge clk);
        check1("drain1_exit", master_enable, 1'b0);
        for (int i = 0; i < 4; i++) step();
        SDA_sync = 1'b0;
        step();
        SDA_sync = 1'b1;
        for (int i = 0; i < BFC; i++) begin
            @(negedge clk);
            check1("glitch_still_waiting", switch_pending, 1'b1);
            check1("glitch_role_held", role, 1'b1);
            step();
        end
        @(negedge clk);
        check1("glitch_switched_role", role, 1'b0);
        check1("glitch_slave_enable", slave_enable, 1'b1);

        // Short request pulse while slave busy: abort, no BUS_WAIT.
        busy_slave = 1'b1; ms_select = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check1("abort_pending", switch_pending, 1'b1);
            check1("abort_slave_enable", slave_enable, 1'b1);
        end
        ms_select = 1'b0;
        step();
        @(negedge clk);
        check1("abort_done", switch_pending, 1'b0);
        check1("abort_role", role, 1'b0);
        busy_slave = 1'b0;
        step();

        // Reset in the middle of BUS_WAIT with target master.
        ms_select = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check1("pre_reset_waiting", switch_pending, 1'b1);
        check1("pre_reset_slave_off", slave_enable, 1'b0);
        #2 n_rst = 1'b0; ms_select = 1'b0;
        #1;
        check1("midrst_role", role, 1'b0);
        check1("midrst_slave_enable", slave_enable, 1'b1);
        check1("midrst_master_enable", master_enable, 1'b0);
        check1("midrst_SDA_out", SDA_out, 1'b1);
        check1("midrst_SCL_out", SCL_out, 1'b1);
        check1("midrst_pending", switch_pending, 1'b0);
        step();
        step();
        n_rst = 1'b1;

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(15) == 0) ms_select = ~ms_select;
            if ($urandom_range(3) == 0) busy_slave = 1'($urandom_range(1));
            if ($urandom_range(3) == 0) busy_master = 1'($urandom_range(1));
            SDA_sync = ($urandom_range(9) != 0);
            SCL_sync = ($urandom_range(9) != 0);
            SDA_out_master = 1'($urandom_range(1));
            SCL_out_master = 1'($urandom_range(1));
            SDA_out_slave = 1'($urandom_range(1));
            SCL_out_slave = 1'($urandom_range(1));
            TX_read_enable_master = 1'($urandom_range(1));
            TX_read_enable_slave = 1'($urandom_range(1));
            RX_write_enable_master = 1'($urandom_range(1));
            RX_write_enable_slave = 1'($urandom_range(1));
            rx_data_master = 8'($urandom);
            rx_data_slave = 8'($urandom);
            set_transaction_complete_master = 1'($urandom_range(1));
            set_transaction_complete_slave = 1'($urandom_range(1));
            ack_error_set_master = 1'($urandom_range(1));
            ack_error_set_slave = 1'($urandom_range(1));
            step();
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
